// File: rtl/hack_cpu_ctrl.sv
// hack_cpu_ctrl: multi-cycle control core of the Hack CPU.
// Fetches instructions over a ready/request ROM port, decodes A- and
// C-instructions, drives an external ALU and sequences RAM reads/writes.
// Owns the A, D and PC registers plus the IR, MDR and write-back latches.
module hack_cpu_ctrl #(
  parameter int AW = 15,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          rom_req,
  output logic [AW-1:0] rom_addr,
  input  logic          rom_ready,
  input  logic [DW-1:0] rom_data,
  output logic          ram_rd,
  output logic          ram_wr,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  input  logic          ram_ready,
  output logic [DW-1:0] alu_x,
  output logic [DW-1:0] alu_y,
  output logic          zx,
  output logic          nx,
  output logic          zy,
  output logic          ny,
  output logic          f,
  output logic          no,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_zr,
  input  logic          alu_ng,
  output logic [AW-1:0] pc
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MEMRD,
    S_EXEC,
    S_MEMWR
  } state_t;

  state_t        state;
  logic [DW-1:0] ir;
  logic [DW-1:0] a_reg;
  logic [DW-1:0] d_reg;
  logic [DW-1:0] mdr;
  logic [DW-1:0] r_reg;
  logic [AW-1:0] wa;
  logic [AW-1:0] pc_inc;
  logic          jmp;

  // Next sequential PC; wraps naturally at the top of the address space.
  assign pc_inc = pc + AW'(1);

  // Jump decision uses the ALU flags of the instruction currently in EXEC.
  assign jmp = (ir[2] & alu_ng) | (ir[1] & alu_zr) | (ir[0] & ~alu_ng & ~alu_zr);

  // ALU operands and control bits follow IR/D/A/MDR continuously.
  assign alu_x = d_reg;
  assign alu_y = ir[12] ? mdr : a_reg;
  assign {zx, nx, zy, ny, f, no} = ir[11:6];

  // Fetch address is the PC; data writes go to the latched old A.
  assign rom_addr  = pc;
  assign ram_addr  = (state == S_MEMWR) ? wa : a_reg[AW-1:0];
  assign ram_wdata = r_reg;

  // Main sequencer: one always_ff owns state, architectural registers and
  // the request strobes. After reset the first FETCH cycle raises rom_req
  // so that all requests are low while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      rom_req <= 1'b0;
      ram_rd  <= 1'b0;
      ram_wr  <= 1'b0;
      pc      <= '0;
      ir      <= '0;
      a_reg   <= '0;
      d_reg   <= '0;
      mdr     <= '0;
      r_reg   <= '0;
      wa      <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (rom_req && rom_ready) begin
            ir      <= rom_data;
            rom_req <= 1'b0;
            state   <= S_DECODE;
          end else begin
            rom_req <= 1'b1;
          end
        end
        S_DECODE: begin
          if (!ir[DW-1]) begin
            a_reg   <= {1'b0, ir[DW-2:0]};
            pc      <= pc_inc;
            rom_req <= 1'b1;
            state   <= S_FETCH;
          end else if (ir[12]) begin
            ram_rd <= 1'b1;
            state  <= S_MEMRD;
          end else begin
            state <= S_EXEC;
          end
        end
        S_MEMRD: begin
          if (ram_ready) begin
            mdr    <= ram_rdata;
            ram_rd <= 1'b0;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_reg <= alu_out;
          wa    <= a_reg[AW-1:0];
          if (ir[5]) a_reg <= alu_out;
          if (ir[4]) d_reg <= alu_out;
          pc <= jmp ? a_reg[AW-1:0] : pc_inc;
          if (ir[3]) begin
            ram_wr <= 1'b1;
            state  <= S_MEMWR;
          end else begin
            rom_req <= 1'b1;
            state   <= S_FETCH;
          end
        end
        S_MEMWR: begin
          if (ram_ready) begin
            ram_wr  <= 1'b0;
            rom_req <= 1'b1;
            state   <= S_FETCH;
          end
        end
        default: begin
          rom_req <= 1'b0;
          ram_rd  <= 1'b0;
          ram_wr  <= 1'b0;
          state   <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// tb_hack_cpu_ctrl: scoreboard bench for hack_cpu_ctrl.
// An instruction-level Hack model runs each time the bench hands out an
// instruction and queues the bus transactions the core must then perform.
module tb_hack_cpu_ctrl;

  localparam int AW = 15;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rom_req;
  logic [AW-1:0] rom_addr;
  logic          rom_ready;
  logic [DW-1:0] rom_data;
  logic          ram_rd;
  logic          ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          ram_ready;
  logic [DW-1:0] alu_x;
  logic [DW-1:0] alu_y;
  logic          zx, nx, zy, ny, f, no;
  logic [DW-1:0] alu_out;
  logic          alu_zr;
  logic          alu_ng;
  logic [AW-1:0] pc;

  hack_cpu_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ready(rom_ready), .rom_data(rom_data),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .alu_x(alu_x), .alu_y(alu_y),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .pc(pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [14:0] addr;
    logic [15:0] data;
    int          cyc;
  } ev_t;

  logic [15:0] rom    [0:32767];
  logic [15:0] tb_ram [0:32767];
  logic [15:0] m_ram  [0:32767];
  logic [15:0] m_a;
  logic [15:0] m_d;
  logic [14:0] m_pc;
  ev_t         exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int wait_mode = 0;
  int fetch_cnt = 0;

  // Hack ALU as defined by its six control bits.
  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0000 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'h0000 : y;
    if (c[2]) yy = ~yy;
    o = c[1] ? (xx + yy) : (xx & yy);
    if (c[0]) o = ~o;
    return o;
  endfunction

  // External ALU instance seen by the core.
  always_comb begin
    alu_out = hack_alu(alu_x, alu_y, {zx, nx, zy, ny, f, no});
    alu_zr  = (alu_out == 16'h0000);
    alu_ng  = alu_out[15];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      n_fail++;
      if (n_fail <= 30)
        $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic push_ev(input int kind, input logic [14:0] addr, input logic [15:0] data,
                         input int cyc);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    e.cyc  = cyc;
    exp_q.push_back(e);
  endtask

  // Executes the instruction at the model PC and queues its bus traffic.
  task automatic model_step();
    logic [15:0] ins, y, res, old_a;
    logic        jmp;
    int          cyc;
    ins = rom[m_pc];
    if (!ins[15]) begin
      m_a  = {1'b0, ins[14:0]};
      m_pc = m_pc + 15'd1;
      cyc  = 2;
    end else begin
      cyc   = 3;
      old_a = m_a;
      if (ins[12]) begin
        push_ev(1, old_a[14:0], 16'h0000, 0);
        y = m_ram[old_a[14:0]];
        cyc++;
      end else begin
        y = old_a;
      end
      res = hack_alu(m_d, y, ins[11:6]);
      if (ins[3]) begin
        push_ev(2, old_a[14:0], res, 0);
        m_ram[old_a[14:0]] = res;
        cyc++;
      end
      if (ins[5]) m_a = res;
      if (ins[4]) m_d = res;
      jmp  = (ins[2] && $signed(res) < 0) || (ins[1] && res == 16'h0000) ||
             (ins[0] && $signed(res) > 0);
      m_pc = jmp ? old_a[14:0] : m_pc + 15'd1;
    end
    push_ev(0, m_pc, 16'h0000, cyc);
  endtask

  task automatic model_reset();
    m_a  = 16'h0000;
    m_d  = 16'h0000;
    m_pc = 15'd0;
    exp_q.delete();
    for (int i = 0; i < 32768; i++) m_ram[i] = tb_ram[i];
    push_ev(0, 15'd0, 16'h0000, 0);
  endtask

  // Loads random memories and overlays the directed program.
  task automatic applyStimulus();
    logic [15:0] prog [0:24];
    prog = '{16'h0005, 16'h0007, 16'hEC10, 16'h0009, 16'hEC10, 16'h0003, 16'hE7C8,
             16'h0064, 16'hFC10, 16'h0065, 16'hE308, 16'hEE90, 16'h0014, 16'hE304,
             16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
             16'hEA90, 16'h0028, 16'hE304, 16'h0032, 16'hFCAA};
    for (int i = 0; i < 32768; i++) begin
      rom[i]    = 16'($urandom);
      tb_ram[i] = 16'($urandom);
    end
    for (int i = 0; i < 25; i++) if (i < 14 || i > 19) rom[i] = prog[i];
    rom[50] = 16'hE308;
    rom[51] = 16'h0066;
    rom[52] = 16'hE308;
    tb_ram[100] = 16'h8000;
    tb_ram[50]  = 16'h0001;
  endtask

  task automatic wait_fetches(input int target, input int budget);
    int c = 0;
    while (fetch_cnt < target && c < budget) begin
      @(negedge clk);
      #3;
      c++;
    end
    if (c >= budget) checkOutput("fetch_progress", 32'(fetch_cnt), 32'(target));
  endtask

  // Memory responder: drives ready/data on the falling edge; an accepted
  // fetch hands the instruction to the model.
  int ram_cnt = 0;
  initial begin
    rom_ready = 1'b0;
    ram_ready = 1'b0;
    rom_data  = 16'h0000;
    ram_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rom_ready = 1'b0;
        ram_ready = 1'b0;
        ram_cnt   = 0;
        continue;
      end
      rom_ready = (wait_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (rom_req && rom_ready) begin
        rom_data = rom[rom_addr];
        model_step();
      end else begin
        rom_data = 16'($urandom);
      end
      if (ram_rd || ram_wr) begin
        if (wait_mode == 2) begin
          ram_ready = (ram_cnt >= 3);
          ram_cnt   = ram_ready ? 0 : ram_cnt + 1;
        end else if (wait_mode == 1) begin
          ram_ready = ($urandom_range(0, 1) == 1);
        end else begin
          ram_ready = 1'b1;
        end
      end else begin
        ram_cnt   = 0;
        ram_ready = (wait_mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
      end
      ram_rdata = ram_rd ? tb_ram[ram_addr] : 16'($urandom);
    end
  end

  // Monitor: samples between edges, pops expected transactions on each
  // completed handshake and checks request stability and instruction timing.
  initial begin
    ev_t         e;
    logic        pend_rom, pend_rd, pend_wr, have_prev;
    logic [14:0] hold_rom, hold_rd, hold_wr;
    logic [15:0] hold_wd;
    int          cyc_now, t_prev, waits;
    pend_rom = 0; pend_rd = 0; pend_wr = 0; have_prev = 0;
    hold_rom = '0; hold_rd = '0; hold_wr = '0; hold_wd = '0;
    cyc_now = 0; t_prev = 0; waits = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        pend_rom = 0; pend_rd = 0; pend_wr = 0; have_prev = 0; waits = 0;
        continue;
      end
      cyc_now++;
      if (pend_rom && rom_req) checkOutput("rom_addr_hold", 32'(rom_addr), 32'(hold_rom));
      if (pend_rd && ram_rd) checkOutput("rd_addr_hold", 32'(ram_addr), 32'(hold_rd));
      if (pend_wr && ram_wr) begin
        checkOutput("wr_addr_hold", 32'(ram_addr), 32'(hold_wr));
        checkOutput("wr_data_hold", 32'(ram_wdata), 32'(hold_wd));
      end
      if ((rom_req && !rom_ready) || (ram_rd && !ram_ready) || (ram_wr && !ram_ready)) waits++;
      if ((rom_req && rom_ready) || (ram_rd && ram_ready) || (ram_wr && ram_ready)) begin
        checkOutput("req_onehot", 32'($countones({rom_req, ram_rd, ram_wr})), 32'(1));
        if (exp_q.size() == 0) begin
          checkOutput("exp_queue_nonempty", 32'(exp_q.size()), 32'(1));
        end else begin
          e = exp_q.pop_front();
          if (rom_req && rom_ready) begin
            checkOutput("fetch_kind", 32'(e.kind), 32'(0));
            checkOutput("fetch_addr", 32'(rom_addr), 32'(e.addr));
            checkOutput("pc_port", 32'(pc), 32'(e.addr));
            if (have_prev && e.cyc != 0)
              checkOutput("instr_cycles", 32'(cyc_now - t_prev - waits), 32'(e.cyc));
          end else if (ram_rd) begin
            checkOutput("rd_kind", 32'(e.kind), 32'(1));
            checkOutput("rd_addr", 32'(ram_addr), 32'(e.addr));
          end else begin
            checkOutput("wr_kind", 32'(e.kind), 32'(2));
            checkOutput("wr_addr", 32'(ram_addr), 32'(e.addr));
            checkOutput("wr_data", 32'(ram_wdata), 32'(e.data));
          end
        end
        if (ram_wr && ram_ready) tb_ram[ram_addr] = ram_wdata;
        if (rom_req && rom_ready) begin
          fetch_cnt++;
          have_prev = 1;
          t_prev    = cyc_now;
          waits     = 0;
        end
      end
      pend_rom = rom_req && !rom_ready;
      pend_rd  = ram_rd && !ram_ready;
      pend_wr  = ram_wr && !ram_ready;
      hold_rom = rom_addr;
      hold_rd  = ram_addr;
      hold_wr  = ram_addr;
      hold_wd  = ram_wdata;
    end
  end

  // Test sequence: directed program, random run, reset during a RAM read.
  initial begin
    int base;
    int c;
    rst_n     = 1'b0;
    wait_mode = 2;
    applyStimulus();
    model_reset();
    #12;
    checkOutput("reset_pc", 32'(pc), 32'(0));
    checkOutput("reset_rom_req", 32'(rom_req), 32'(0));
    checkOutput("reset_ram_rd", 32'(ram_rd), 32'(0));
    checkOutput("reset_ram_wr", 32'(ram_wr), 32'(0));
    @(negedge clk);
    #3;
    rst_n = 1'b1;

    wait_fetches(23, 800);
    checkOutput("ram3_d_plus_1", 32'(tb_ram[3]), 32'h000A);
    checkOutput("ram101_neg", 32'(tb_ram[101]), 32'h8000);
    checkOutput("ram50_m_minus_1", 32'(tb_ram[50]), 32'h0000);
    checkOutput("ram0_a_from_alu", 32'(tb_ram[0]), 32'h0000);
    checkOutput("ram102_d_zero", 32'(tb_ram[102]), 32'h0000);

    wait_mode = 1;
    wait_fetches(23 + 300, 20000);

    c = 0;
    do begin
      @(negedge clk);
      #3;
      c++;
    end while (!ram_rd && c < 4000);
    checkOutput("memrd_seen", 32'(ram_rd), 32'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_ram_rd", 32'(ram_rd), 32'(0));
    checkOutput("async_rst_rom_req", 32'(rom_req), 32'(0));
    checkOutput("async_rst_ram_wr", 32'(ram_wr), 32'(0));
    checkOutput("async_rst_pc", 32'(pc), 32'(0));
    rom[0]    = 16'hE308;
    tb_ram[0] = 16'hBEEF;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #3;
    base  = fetch_cnt;
    rst_n = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      #3;
      c++;
    end while (!rom_req && c < 4);
    checkOutput("restart_rom_req", 32'(rom_req), 32'(1));
    checkOutput("restart_rom_addr", 32'(rom_addr), 32'(0));
    wait_fetches(base + 2, 200);
    checkOutput("restart_a_d_zero", 32'(tb_ram[0]), 32'h0000);

    wait_fetches(base + 102, 8000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
